// File: rtl/serial_frame_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_pkg
//  Description : Shared types, line-level constants and the parity helper
//                used by the serial frame receiver.
//  Contents    : state_t    - receiver FSM state encoding
//                START_BIT  - line level of a start bit
//                STOP_BIT   - line level of a valid stop bit
//                parity_ok  - parity check on received data + parity bit
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Data is zero-extended to 32 bits by the caller; the extra zeros do
    // not change the XOR reduction.
    function automatic logic parity_ok(input logic [31:0] data,
                                       input logic        rx_bit,
                                       input logic        odd);
        return ((^data) ^ rx_bit) == odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_frame_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_receiver_if
//  Description : Valid/ready word stream leaving the serial frame receiver.
//  Signals     : dout       - received word, stable while dout_valid=1
//                dout_valid - dout holds an undelivered word
//                dout_ready - consumer accepts on valid&ready edges
//  Modports    : master - receiver side, slave - consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_receiver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_receiver_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rx_out_buffer
//  Description : One-entry valid/ready holding register for received words.
//                A load wins over a drain on the same edge, so a word that
//                arrives while the old one is being taken replaces it.
//  Ports       : clk        - clock
//                clr        - asynchronous active-low reset
//                load       - store load_data this edge
//                load_data  - word to store
//                dout_ready - consumer accepts the held word
//                dout       - held word
//                dout_valid - held word not yet delivered
//                accept     - a load this edge would not lose a word
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_out_buffer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             clr,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_data,
    input  wire logic             dout_ready,
    output logic      [WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  accept
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (dout_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Empty, or the held word leaves on this very edge.
    assign accept     = ~r_valid | dout_ready;
    assign dout       = r_data;
    assign dout_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_receiver
//  Description : Receive end of the bit-serial link. One line bit per clk
//                edge: start bit, WIDTH data bits LSB first, optional parity
//                bit, stop bit. Good words go to a one-entry valid/ready
//                buffer; parity, framing and overrun errors are flagged with
//                registered one-cycle pulses.
//  Ports       : clk        - clock
//                clr        - asynchronous active-low reset
//                din        - serial line, idles high
//                out_if     - dout / dout_valid / dout_ready word stream
//                busy       - FSM not in IDLE
//                parity_err - parity mismatch, word dropped
//                frame_err  - stop bit was 0, word dropped
//                overrun    - good word while buffer full, new word dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_receiver
    import serial_frame_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  wire logic                      clk,
    input  wire logic                      clr,
    input  wire logic                      din,
    serial_frame_receiver_if.master        out_if,
    output logic                           busy,
    output logic                           parity_err,
    output logic                           frame_err,
    output logic                           overrun
);

    localparam int                c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_shift;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_busy;
    logic                 w_parity_good;
    logic                 w_stop_edge;
    logic                 w_stop_ok;
    logic                 w_good;
    logic                 w_load;
    logic                 w_accept;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and busy
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (din == START_BIT) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (r_cnt == c_last) begin
                    w_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_next = STOP;
            end
            STOP: begin
                // Back-to-back frames: a 0 on the next edge is a new start.
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit counter and shift register. New bits enter at the MSB so that,
    // after WIDTH shifts, the first bit received sits in bit 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == IDLE && din == START_BIT) begin
                r_cnt <= '0;
            end else if (r_state == DATA) begin
                r_shift <= {din, r_shift[WIDTH-1:1]};
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Parity capture and check
    // ------------------------------------------------------------------
    generate
        if (PARITY_EN != 0) begin : g_parity_on
            logic r_rx_parity;

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    r_rx_parity <= 1'b0;
                end else if (r_state == PARITY) begin
                    r_rx_parity <= din;
                end
            end

            assign w_parity_good = parity_ok(32'(r_shift), r_rx_parity,
                                             1'(PARITY_ODD));
        end else begin : g_parity_off
            assign w_parity_good = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stop-edge decisions. Framing error outranks parity error; overrun
    // only applies to otherwise good words.
    // ------------------------------------------------------------------
    assign w_stop_edge = (r_state == STOP);
    assign w_stop_ok   = (din == STOP_BIT);
    assign w_good      = w_stop_edge & w_stop_ok & w_parity_good;
    assign w_load      = w_good & w_accept;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= w_stop_edge & w_stop_ok & ~w_parity_good;
            r_frame_err  <= w_stop_edge & ~w_stop_ok;
            r_overrun    <= w_good & ~w_accept;
        end
    end

    rx_out_buffer #(
        .WIDTH (WIDTH)
    ) u_out_buffer (
        .clk        (clk),
        .clr        (clr),
        .load       (w_load),
        .load_data  (r_shift),
        .dout_ready (out_if.dout_ready),
        .dout       (out_if.dout),
        .dout_valid (out_if.dout_valid),
        .accept     (w_accept)
    );

    assign busy       = w_busy;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
